// File: rtl/pwm_ctrl_pkg.sv
// Shared types and default sizes for the PWM duty-cycle controller.
// The PWM generator imports the same package so both agree on duty width and range.
package pwm_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_RAMP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DOWN = 2'd2
    } step_t;

    localparam int DEF_DUTY_W    = 4;
    localparam int DEF_DUTY_MAX  = 10;
    localparam int DEF_DUTY_INIT = 5;

endpackage

// File: rtl/pwm_period_divider.sv
// Counts PWM period boundaries and strobes o_step on every RAMP_PERIODS-th one.
// The strobe is combinational so the caller can act on the same boundary edge.
module pwm_period_divider #(
    parameter int RAMP_PERIODS = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    input  logic i_period_end,
    output logic o_step
);

    localparam int CNT_W = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(RAMP_PERIODS - 1);

    logic [CNT_W-1:0] cnt;
    logic             hit;

    // A clear in the same cycle as a boundary wins: that boundary is not counted.
    assign hit    = i_en && i_period_end && !i_clr;
    assign o_step = hit && (cnt == LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            cnt <= '0;
        end else if (hit) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pwm_duty_ctrl.sv
// Duty-cycle controller: arbitrates manual +/-1 requests and automatic ramps,
// committing every duty change on a PWM period boundary so the waveform never glitches.
module pwm_duty_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int DUTY_W       = DEF_DUTY_W,
    parameter int DUTY_MAX     = DEF_DUTY_MAX,
    parameter int DUTY_INIT    = DEF_DUTY_INIT,
    parameter int RAMP_PERIODS = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_period_end,
    input  logic              i_inc_req,
    input  logic              i_dec_req,
    input  logic              i_ramp_start,
    input  logic [DUTY_W-1:0] i_ramp_target,
    input  logic              i_ramp_abort,
    output logic [DUTY_W-1:0] o_duty,
    output logic              o_ramp_busy,
    output logic              o_req_drop,
    output logic              o_sat
);

    localparam logic [DUTY_W-1:0] MAX_V  = DUTY_W'(DUTY_MAX);
    localparam logic [DUTY_W-1:0] INIT_V = DUTY_W'(DUTY_INIT);

    function automatic logic [DUTY_W-1:0] clamp_target(input logic [DUTY_W-1:0] t);
        return (t > MAX_V) ? MAX_V : t;
    endfunction

    // Result is {saturated, new_duty}; a clamped step leaves the duty untouched.
    function automatic logic [DUTY_W:0] apply_step(input logic [DUTY_W-1:0] d, input step_t s);
        logic [DUTY_W:0] r;
        r = {1'b0, d};
        case (s)
            STEP_UP:   r = (d >= MAX_V) ? {1'b1, d} : {1'b0, d + DUTY_W'(1)};
            STEP_DOWN: r = (d == '0)    ? {1'b1, d} : {1'b0, d - DUTY_W'(1)};
            default:   r = {1'b0, d};
        endcase
        return r;
    endfunction

    function automatic logic [DUTY_W-1:0] step_toward(input logic [DUTY_W-1:0] d,
                                                       input logic [DUTY_W-1:0] t);
        return (t > d) ? d + DUTY_W'(1) : d - DUTY_W'(1);
    endfunction

    state_t            state, state_nx;
    step_t             pend, pend_nx;
    logic [DUTY_W-1:0] duty, duty_nx;
    logic [DUTY_W-1:0] target, target_nx;
    logic [DUTY_W-1:0] tgt_clamped;
    logic [DUTY_W:0]   stepped;
    logic              busy, req_drop, sat;
    logic              drop_nx, sat_nx;
    logic              manual;
    step_t             manual_dir;
    logic              abort_hit;
    logic              div_clr;
    logic              ramp_step;

    assign manual      = i_inc_req ^ i_dec_req;
    assign manual_dir  = i_inc_req ? STEP_UP : STEP_DOWN;
    assign tgt_clamped = clamp_target(i_ramp_target);
    assign abort_hit   = i_ramp_abort && (state == ST_RAMP);
    assign stepped     = apply_step(duty, pend);
    assign div_clr     = i_ramp_start || i_ramp_abort || (state != ST_RAMP);

    pwm_period_divider #(
        .RAMP_PERIODS(RAMP_PERIODS)
    ) u_divider (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clr       (div_clr),
        .i_en        (state == ST_RAMP),
        .i_period_end(i_period_end),
        .o_step      (ramp_step)
    );

    always_comb begin
        state_nx  = state;
        pend_nx   = pend;
        duty_nx   = duty;
        target_nx = target;
        drop_nx   = 1'b0;
        sat_nx    = 1'b0;

        if (abort_hit) begin
            state_nx = ST_IDLE;
            pend_nx  = STEP_NONE;
        end else if (i_ramp_start) begin
            target_nx = tgt_clamped;
            pend_nx   = STEP_NONE;
            state_nx  = (tgt_clamped == duty) ? ST_IDLE : ST_RAMP;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (manual) begin
                        state_nx = ST_PEND;
                        pend_nx  = manual_dir;
                    end
                end
                ST_PEND: begin
                    if (i_period_end) begin
                        // A request arriving on the boundary itself queues for the next period.
                        {sat_nx, duty_nx} = stepped;
                        state_nx = manual ? ST_PEND : ST_IDLE;
                        pend_nx  = manual ? manual_dir : STEP_NONE;
                    end else if (manual) begin
                        if (manual_dir == pend) begin
                            drop_nx = 1'b1;
                        end else begin
                            state_nx = ST_IDLE;
                            pend_nx  = STEP_NONE;
                        end
                    end
                end
                ST_RAMP: begin
                    drop_nx = i_inc_req || i_dec_req;
                    if (ramp_step) begin
                        duty_nx = step_toward(duty, target);
                        if (duty_nx == target) begin
                            state_nx = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                    pend_nx  = STEP_NONE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            pend     <= STEP_NONE;
            duty     <= INIT_V;
            busy     <= 1'b0;
            req_drop <= 1'b0;
            sat      <= 1'b0;
        end else begin
            state    <= state_nx;
            pend     <= pend_nx;
            duty     <= duty_nx;
            busy     <= (state_nx == ST_RAMP);
            req_drop <= drop_nx;
            sat      <= sat_nx;
        end
    end

    // The ramp target is only consulted while ramping, so it needs no reset.
    always_ff @(posedge i_clk) begin
        target <= target_nx;
    end

    assign o_duty      = duty;
    assign o_ramp_busy = busy;
    assign o_req_drop  = req_drop;
    assign o_sat       = sat;

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Bench for pwm_duty_ctrl: expected duty per PWM boundary is queued when stimulus
// is applied and popped for comparison after each boundary edge.
module tb_pwm_duty_ctrl;

    localparam int DW = 4;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b0;
    logic          i_period_end = 1'b0;
    logic          i_inc_req = 1'b0;
    logic          i_dec_req = 1'b0;
    logic          i_ramp_start = 1'b0;
    logic [DW-1:0] i_ramp_target = '0;
    logic          i_ramp_abort = 1'b0;
    logic [DW-1:0] o_duty;
    logic          o_ramp_busy;
    logic          o_req_drop;
    logic          o_sat;

    int total = 0;
    int bad = 0;
    int drop_cnt = 0;
    int sat_cnt = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_d;
    logic          exp_b;
    int d0, s0;

    pwm_duty_ctrl dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_period_end (i_period_end),
        .i_inc_req    (i_inc_req),
        .i_dec_req    (i_dec_req),
        .i_ramp_start (i_ramp_start),
        .i_ramp_target(i_ramp_target),
        .i_ramp_abort (i_ramp_abort),
        .o_duty       (o_duty),
        .o_ramp_busy  (o_ramp_busy),
        .o_req_drop   (o_req_drop),
        .o_sat        (o_sat)
    );

    always #5 i_clk = ~i_clk;

    // Pulse counters: a pulse held two cycles would count twice.
    always @(negedge i_clk) begin
        if (o_req_drop) drop_cnt++;
        if (o_sat) sat_cnt++;
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic boundary();
        i_period_end = 1'b1;
        tick();
        i_period_end = 1'b0;
    endtask

    task automatic period();
        repeat (3) tick();
        boundary();
    endtask

    task automatic pulse_inc();
        i_inc_req = 1'b1;
        tick();
        i_inc_req = 1'b0;
    endtask

    task automatic pulse_dec();
        i_dec_req = 1'b1;
        tick();
        i_dec_req = 1'b0;
    endtask

    task automatic start_ramp(input logic [DW-1:0] t);
        i_ramp_start = 1'b1;
        i_ramp_target = t;
        tick();
        i_ramp_start = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (2) tick();
        i_rst = 1'b0;
        total++; if (o_duty !== 4'd5) begin bad++; $display("FAIL reset_duty got=%0d want=5", o_duty); end
        total++; if (o_ramp_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", o_ramp_busy); end
        total++; if (o_req_drop !== 1'b0) begin bad++; $display("FAIL reset_drop got=%0b want=0", o_req_drop); end
        total++; if (o_sat !== 1'b0) begin bad++; $display("FAIL reset_sat got=%0b want=0", o_sat); end
    endtask

    task automatic test_inc();
        d0 = drop_cnt; s0 = sat_cnt;
        tick();
        pulse_inc();
        total++; if (o_duty !== 4'd5) begin bad++; $display("FAIL inc_hold got=%0d want=5", o_duty); end
        exp_q.push_back(4'd6);
        tick();
        total++; if (o_duty !== 4'd5) begin bad++; $display("FAIL inc_pre_boundary got=%0d want=5", o_duty); end
        boundary();
        exp_d = exp_q.pop_front();
        total++; if (o_duty !== exp_d) begin bad++; $display("FAIL inc_applied got=%0d want=%0d", o_duty, exp_d); end
        exp_q.push_back(4'd6);
        period();
        exp_d = exp_q.pop_front();
        total++; if (o_duty !== exp_d) begin bad++; $display("FAIL inc_stable got=%0d want=%0d", o_duty, exp_d); end
        repeat (2) tick();
        total++; if (drop_cnt - d0 !== 0) begin bad++; $display("FAIL inc_drop got=%0d want=0", drop_cnt - d0); end
        total++; if (sat_cnt - s0 !== 0) begin bad++; $display("FAIL inc_sat got=%0d want=0", sat_cnt - s0); end
    endtask

    task automatic test_double();
        d0 = drop_cnt;
        pulse_inc();
        pulse_inc();
        exp_q.push_back(4'd7);
        period();
        exp_d = exp_q.pop_front();
        total++; if (o_duty !== exp_d) begin bad++; $display("FAIL double_inc got=%0d want=%0d", o_duty, exp_d); end
        repeat (2) tick();
        total++; if (drop_cnt - d0 !== 1) begin bad++; $display("FAIL double_drop got=%0d want=1", drop_cnt - d0); end
        pulse_inc();
        pulse_dec();
        exp_q.push_back(4'd7);
        period();
        exp_d = exp_q.pop_front();
        total++; if (o_duty !== exp_d) begin bad++; $display("FAIL inc_dec_cancel got=%0d want=%0d", o_duty, exp_d); end
        i_inc_req = 1'b1; i_dec_req = 1'b1;
        tick();
        i_inc_req = 1'b0; i_dec_req = 1'b0;
        exp_q.push_back(4'd7);
        period();
        exp_d = exp_q.pop_front();
        total++; if (o_duty !== exp_d) begin bad++; $display("FAIL both_same_cycle got=%0d want=%0d", o_duty, exp_d); end
        repeat (2) tick();
        total++; if (drop_cnt - d0 !== 1) begin bad++; $display("FAIL cancel_drop got=%0d want=1", drop_cnt - d0); end
    endtask

    task automatic test_coincident();
        i_inc_req = 1'b1; i_period_end = 1'b1;
        tick();
        i_inc_req = 1'b0; i_period_end = 1'b0;
        total++; if (o_duty !== 4'd7) begin bad++; $display("FAIL coinc_idle_hold got=%0d want=7", o_duty); end
        exp_q.push_back(4'd8);
        period();
        exp_d = exp_q.pop_front();
        total++; if (o_duty !== exp_d) begin bad++; $display("FAIL coinc_idle_next got=%0d want=%0d", o_duty, exp_d); end
        pulse_inc();
        i_inc_req = 1'b1; i_period_end = 1'b1;
        tick();
        i_inc_req = 1'b0; i_period_end = 1'b0;
        total++; if (o_duty !== 4'd9) begin bad++; $display("FAIL coinc_pend_apply got=%0d want=9", o_duty); end
        exp_q.push_back(4'd10);
        period();
        exp_d = exp_q.pop_front();
        total++; if (o_duty !== exp_d) begin bad++; $display("FAIL coinc_pend_next got=%0d want=%0d", o_duty, exp_d); end
    endtask

    task automatic test_sat_high();
        s0 = sat_cnt;
        pulse_inc();
        exp_q.push_back(4'd10);
        period();
        exp_d = exp_q.pop_front();
        total++; if (o_duty !== exp_d) begin bad++; $display("FAIL sat_high_duty got=%0d want=%0d", o_duty, exp_d); end
        repeat (2) tick();
        total++; if (sat_cnt - s0 !== 1) begin bad++; $display("FAIL sat_high_pulse got=%0d want=1", sat_cnt - s0); end
    endtask

    task automatic test_ramp_down_sat_low();
        start_ramp(4'd0);
        total++; if (o_ramp_busy !== 1'b1) begin bad++; $display("FAIL rdown_busy_rise got=%0b want=1", o_ramp_busy); end
        for (int k = 1; k <= 40; k++) begin
            exp_q.push_back(DW'(10 - k / 4));
            period();
            exp_d = exp_q.pop_front();
            exp_b = (k < 40);
            total++; if (o_duty !== exp_d) begin bad++; $display("FAIL rdown_duty k=%0d got=%0d want=%0d", k, o_duty, exp_d); end
            total++; if (o_ramp_busy !== exp_b) begin bad++; $display("FAIL rdown_busy k=%0d got=%0b want=%0b", k, o_ramp_busy, exp_b); end
        end
        s0 = sat_cnt;
        pulse_dec();
        exp_q.push_back(4'd0);
        period();
        exp_d = exp_q.pop_front();
        total++; if (o_duty !== exp_d) begin bad++; $display("FAIL sat_low_duty got=%0d want=%0d", o_duty, exp_d); end
        repeat (2) tick();
        total++; if (sat_cnt - s0 !== 1) begin bad++; $display("FAIL sat_low_pulse got=%0d want=1", sat_cnt - s0); end
    endtask

    task automatic test_ramp_up();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        d0 = drop_cnt;
        start_ramp(4'd8);
        total++; if (o_ramp_busy !== 1'b1) begin bad++; $display("FAIL rup_busy_rise got=%0b want=1", o_ramp_busy); end
        for (int k = 1; k <= 16; k++) begin
            if (k == 6) pulse_inc();
            exp_d = (5 + k / 4 > 8) ? 4'd8 : DW'(5 + k / 4);
            exp_q.push_back(exp_d);
            period();
            exp_d = exp_q.pop_front();
            exp_b = (exp_d != 4'd8);
            total++; if (o_duty !== exp_d) begin bad++; $display("FAIL rup_duty k=%0d got=%0d want=%0d", k, o_duty, exp_d); end
            total++; if (o_ramp_busy !== exp_b) begin bad++; $display("FAIL rup_busy k=%0d got=%0b want=%0b", k, o_ramp_busy, exp_b); end
        end
        repeat (2) tick();
        total++; if (drop_cnt - d0 !== 1) begin bad++; $display("FAIL rup_manual_drop got=%0d want=1", drop_cnt - d0); end
    endtask

    task automatic test_ramp_sat_abort();
        start_ramp(4'd15);
        for (int k = 1; k <= 12; k++) begin
            exp_d = (8 + k / 4 > 10) ? 4'd10 : DW'(8 + k / 4);
            exp_q.push_back(exp_d);
            period();
            exp_d = exp_q.pop_front();
            exp_b = (exp_d != 4'd10);
            total++; if (o_duty !== exp_d) begin bad++; $display("FAIL rsat_duty k=%0d got=%0d want=%0d", k, o_duty, exp_d); end
            total++; if (o_ramp_busy !== exp_b) begin bad++; $display("FAIL rsat_busy k=%0d got=%0b want=%0b", k, o_ramp_busy, exp_b); end
        end
        start_ramp(4'd0);
        for (int k = 1; k <= 12; k++) begin
            exp_q.push_back(DW'(10 - k / 4));
            period();
            exp_d = exp_q.pop_front();
            total++; if (o_duty !== exp_d) begin bad++; $display("FAIL rabort_pre k=%0d got=%0d want=%0d", k, o_duty, exp_d); end
        end
        i_ramp_abort = 1'b1;
        tick();
        i_ramp_abort = 1'b0;
        total++; if (o_ramp_busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%0b want=0", o_ramp_busy); end
        total++; if (o_duty !== 4'd7) begin bad++; $display("FAIL abort_duty got=%0d want=7", o_duty); end
        for (int k = 1; k <= 8; k++) begin
            exp_q.push_back(4'd7);
            period();
            exp_d = exp_q.pop_front();
            total++; if (o_duty !== exp_d) begin bad++; $display("FAIL abort_hold k=%0d got=%0d want=%0d", k, o_duty, exp_d); end
        end
    endtask

    task automatic test_start_abort();
        start_ramp(4'd7);
        total++; if (o_ramp_busy !== 1'b0) begin bad++; $display("FAIL same_target_busy got=%0b want=0", o_ramp_busy); end
        start_ramp(4'd9);
        total++; if (o_ramp_busy !== 1'b1) begin bad++; $display("FAIL retarget_busy got=%0b want=1", o_ramp_busy); end
        exp_q.push_back(4'd7);
        period();
        exp_d = exp_q.pop_front();
        total++; if (o_duty !== exp_d) begin bad++; $display("FAIL sa_first got=%0d want=%0d", o_duty, exp_d); end
        i_ramp_start = 1'b1; i_ramp_target = 4'd2; i_ramp_abort = 1'b1;
        tick();
        i_ramp_start = 1'b0; i_ramp_abort = 1'b0;
        total++; if (o_ramp_busy !== 1'b0) begin bad++; $display("FAIL sa_abort_wins got=%0b want=0", o_ramp_busy); end
        for (int k = 1; k <= 8; k++) begin
            exp_q.push_back(4'd7);
            period();
            exp_d = exp_q.pop_front();
            total++; if (o_duty !== exp_d) begin bad++; $display("FAIL sa_hold k=%0d got=%0d want=%0d", k, o_duty, exp_d); end
        end
    endtask

    task automatic test_reset_mid_ramp();
        start_ramp(4'd0);
        for (int k = 1; k <= 16; k++) begin
            exp_q.push_back(DW'(7 - k / 4));
            period();
            exp_d = exp_q.pop_front();
            total++; if (o_duty !== exp_d) begin bad++; $display("FAIL rmid_pre k=%0d got=%0d want=%0d", k, o_duty, exp_d); end
        end
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        total++; if (o_duty !== 4'd5) begin bad++; $display("FAIL rmid_duty got=%0d want=5", o_duty); end
        total++; if (o_ramp_busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%0b want=0", o_ramp_busy); end
        for (int k = 1; k <= 8; k++) begin
            exp_q.push_back(4'd5);
            period();
            exp_d = exp_q.pop_front();
            total++; if (o_duty !== exp_d) begin bad++; $display("FAIL rmid_after k=%0d got=%0d want=%0d", k, o_duty, exp_d); end
            total++; if (o_ramp_busy !== 1'b0) begin bad++; $display("FAIL rmid_after_busy k=%0d got=%0b want=0", k, o_ramp_busy); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_inc();
        test_double();
        test_coincident();
        test_sat_high();
        test_ramp_down_sat_low();
        test_ramp_up();
        test_ramp_sat_abort();
        test_start_abort();
        test_reset_mid_ramp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_duty_ctrl.md
# pwm_duty_ctrl

Duty-cycle controller for the PWM generator. It accepts single-step increase/decrease requests and automatic ramp commands, and arbitrates between them. It applies every duty change only at a PWM period boundary, so the output waveform never glitches. It sits between the synchronised, debounced button logic and the PWM counter/comparator, and drives the comparator's duty operand.

## Interface
Parameters:
- DUTY_W, 4, width of duty value
- DUTY_MAX, 10, duty steps per PWM period (100 %)
- DUTY_INIT, 5, duty after reset (50 %)
- RAMP_PERIODS, 4, PWM periods between automatic ramp steps (≥1)

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous, active-high reset
- i_period_end  in  1  one-cycle pulse from PWM counter on its last count of a period
- i_inc_req  in  1  one-cycle pulse: request duty +1
- i_dec_req  in  1  one-cycle pulse: request duty −1
- i_ramp_start  in  1  one-cycle pulse: start ramp to i_ramp_target
- i_ramp_target  in  DUTY_W  ramp target, sampled with i_ramp_start
- i_ramp_abort  in  1  one-cycle pulse: stop ramp, hold current duty
- o_duty  out  DUTY_W  duty applied to PWM comparator, 0..DUTY_MAX
- o_ramp_busy  out  1  high while in RAMP
- o_req_drop  out  1  one-cycle pulse: a manual request was discarded
- o_sat  out  1  one-cycle pulse: an applied step was clamped at 0 or DUTY_MAX

## Operation
- States: IDLE, PEND (one manual step of ±1 registered), RAMP.
- IDLE:
  - inc alone → PEND(+1).
  - dec alone → PEND(−1).
  - inc and dec in the same cycle → no effect, no drop.
- PEND:
  - Same-direction request → ignored, o_req_drop.
  - Opposite request → cancels the pending step, return to IDLE.
  - inc+dec together → ignored.
  - On i_period_end → apply the step, return to IDLE.
  - If the step would leave 0..DUTY_MAX, o_duty is unchanged and o_sat pulses.
- i_ramp_start (any state):
  - Clamp the target to DUTY_MAX and latch it.
  - Discard any pending manual step.
  - Clear the period counter.
  - If target == o_duty, go to IDLE with o_ramp_busy kept low; otherwise go to RAMP.
- RAMP:
  - Count i_period_end pulses. On the RAMP_PERIODS-th pulse, step o_duty by 1 toward the target and clear the counter.
  - When o_duty reaches the target, go to IDLE.
  - Manual requests → o_req_drop, no effect.
  - i_ramp_start → retarget as above. The counter restarts.
- i_ramp_abort: in RAMP → IDLE with o_duty held. In other states → no effect.
- Priority within one cycle: i_ramp_abort > i_ramp_start > manual requests.
- Arithmetic: unsigned DUTY_W. Never wrap past 0 or DUTY_MAX. Targets greater than DUTY_MAX saturate to DUTY_MAX.

## Timing
- Reset (i_rst sampled high at a clock edge): o_duty = DUTY_INIT, state IDLE, period counter 0, o_ramp_busy/o_req_drop/o_sat = 0. Reset mid-ramp or mid-pending discards all work.
- o_duty changes only on the edge that samples i_period_end high. It is stable for every full PWM period.
- A manual request in cycle t is applied at the first i_period_end sampled at t+1 or later. A request coincident with i_period_end waits for the following period.
- o_req_drop and o_sat are registered. They are asserted the cycle after the causing edge, for exactly 1 cycle.
- o_ramp_busy rises the cycle after i_ramp_start. It falls the cycle after the final step or abort.
- Ramp latency: with period length P cycles, the first step lands RAMP_PERIODS period boundaries after the start. A full ramp takes |target−duty|·RAMP_PERIODS boundaries.
- All outputs are registered. No combinational input→output paths.

## Structure
- Package pwm_ctrl_pkg:
  - state enum (IDLE/PEND/RAMP)
  - step encoding (NONE/UP/DOWN)
  - default DUTY_W/DUTY_MAX constants, shared with the PWM generator
- One sub-module, pwm_period_divider: counts i_period_end pulses up to RAMP_PERIODS, with sync clear; outputs a one-cycle step strobe.

## Test plan
- Reset, then inc pulse mid-period → o_duty stays 5 until the next i_period_end edge, then 6. No drop, no sat.
- Two inc pulses in one period → o_duty = 6 after the boundary, o_req_drop pulses once. Inc then dec in the same period → o_duty stays 5.
- Set duty to 10, then inc → o_duty stays 10 and o_sat pulses. Duty 0 + dec → stays 0 and o_sat pulses.
- Ramp from 5 to target 8 with RAMP_PERIODS=4 → o_duty = 6/7/8 at boundaries 4/8/12. o_ramp_busy falls after 8. A manual inc mid-ramp gives o_req_drop.
- Ramp target 15 → saturates to 10. Abort at duty 7 → o_duty holds 7 and busy falls. Start+abort in the same cycle → abort wins.
- Assert i_rst mid-ramp at duty 3 → next cycle o_duty = 5, busy = 0, and no step occurs at later boundaries.
